// File: rtl/train_timer_arbiter.sv
// train_timer_arbiter: round-robin arbiter for one shared millisecond timer.
// Four requesters compete; the winner's 16-bit duration is loaded, counted
// down in 1 ms ticks derived from a TICK_DIV-cycle prescaler, and completion
// is signalled with a one-cycle done pulse to the owner.
// Optional feature: define TRAIN_TIMER_ABORT_EN to add an abort input that
// cancels a granted request during LOAD or RUN without a done pulse.
module train_timer_arbiter #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk_100mhz,
  input  logic        rst,
`ifdef TRAIN_TIMER_ABORT_EN
  input  logic        abort,
`endif
  input  logic [3:0]  req,
  input  logic [63:0] dur_ms,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic        tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Prescaler value in the tick cycle, and the value one cycle before it
  // (used to register tick so it lines up with the wrap cycle).
  localparam logic [16:0] PRESC_LAST = 17'(TICK_DIV - 1);
  localparam logic [16:0] PRESC_PRE  = 17'(TICK_DIV - 2);

  state_t      r_state;
  logic [3:0]  r_gnt;
  logic [3:0]  r_done;
  logic        r_busy;
  logic        r_tick;
  logic [16:0] r_presc;
  logic [15:0] r_remaining;
  logic [1:0]  r_last;
  logic [1:0]  r_win;

  logic [1:0]  w_pick;
  logic [15:0] w_slice;
  logic        w_abort;

  // Round-robin search starting just after the previous winner; the last
  // candidate examined is the previous winner itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  assign w_pick  = rr_pick(req, r_last);
  assign w_slice = dur_ms[{r_win, 4'b0000} +: 16];

`ifdef TRAIN_TIMER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Arbitration FSM, prescaler and countdown with registered outputs.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0000;
      r_done      <= 4'b0000;
      r_busy      <= 1'b0;
      r_tick      <= 1'b0;
      r_presc     <= 17'd0;
      r_remaining <= 16'd0;
      r_last      <= 2'd3;
      r_win       <= 2'd0;
    end else if (w_abort && (r_state == S_LOAD || r_state == S_RUN)) begin
      // Cancel the current owner; it still counts as the last winner.
      r_state     <= S_IDLE;
      r_gnt       <= 4'b0000;
      r_done      <= 4'b0000;
      r_busy      <= 1'b0;
      r_tick      <= 1'b0;
      r_presc     <= 17'd0;
      r_remaining <= 16'd0;
      r_last      <= r_win;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 4'b0000;
          r_tick <= 1'b0;
          if (req != 4'b0000) begin
            r_win   <= w_pick;
            r_gnt   <= onehot(w_pick);
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_remaining <= w_slice;
          r_last      <= r_win;
          r_presc     <= 17'd0;
          r_tick      <= 1'b0;
          if (w_slice != 16'd0) begin
            r_state <= S_RUN;
          end else begin
            r_done  <= onehot(r_win);
            r_state <= S_DONE;
          end
        end
        S_RUN: begin
          if (r_presc == PRESC_LAST) begin
            // Tick cycle: prescaler wraps and one millisecond elapses.
            r_presc     <= 17'd0;
            r_tick      <= 1'b0;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_done  <= onehot(r_win);
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_presc <= r_presc + 17'd1;
            r_tick  <= (r_presc == PRESC_PRE);
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_done  <= 4'b0000;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
          r_tick  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 4'b0000;
          r_done      <= 4'b0000;
          r_busy      <= 1'b0;
          r_tick      <= 1'b0;
          r_presc     <= 17'd0;
          r_remaining <= 16'd0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign tick = r_tick;

endmodule

// File: tb/tb_train_timer_arbiter.sv
// tb_train_timer_arbiter: directed scenarios with a done-pulse scoreboard
// for train_timer_arbiter at TICK_DIV = 4.
module tb_train_timer_arbiter;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] dur_ms;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        tick;
`ifdef TRAIN_TIMER_ABORT_EN
  logic        abort;
`endif

  train_timer_arbiter #(.TICK_DIV(TD)) dut (
    .clk_100mhz (clk),
    .rst        (rst),
`ifdef TRAIN_TIMER_ABORT_EN
    .abort      (abort),
`endif
    .req        (req),
    .dur_ms     (dur_ms),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    int         edge_n;
  } exp_t;

  exp_t sb_q[$];
  int   tick_q[$];
  int   ecnt    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   s;
  int   s2;

  // Count rising edges; edge number k is the edge that produces cycle k.
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] vec, input int edge_n);
    exp_t e;
    e.vec    = vec;
    e.edge_n = edge_n;
    sb_q.push_back(e);
  endtask

  // Record the edge number of every tick strobe.
  always @(negedge clk) if (tick) tick_q.push_back(ecnt);

  // Scoreboard monitor: every done pulse must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done != 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=%b at edge %0d, expected none", done, ecnt);
      end else begin
        e = sb_q.pop_front();
        check("done_vec", int'(done), int'(e.vec));
        check("done_edge", ecnt, e.edge_n);
        check("gnt_at_done", int'(gnt), int'(e.vec));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    dur_ms = 64'd0;
`ifdef TRAIN_TIMER_ABORT_EN
    abort  = 1'b0;
`endif
    wait_neg(2);
    check("rst_gnt",  int'(gnt),  0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(tick), 0);
    rst = 1'b0;

    // A: single request, 3 ms.
    req    = 4'b0001;
    dur_ms = 64'd3;
    s      = ecnt + 1;
    push(4'b0001, s + 13);
    tick_q.delete();
    wait_neg(1);
    check("A_gnt",  int'(gnt),  1);
    check("A_busy", int'(busy), 1);
    wait_neg(13);
    req = 4'b0000;
    wait_neg(1);
    check("A_busy_end", int'(busy), 0);
    check("A_gnt_end",  int'(gnt),  0);
    check("A_tick_cnt", tick_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check("A_tick_edge", (i < tick_q.size()) ? tick_q[i] : -1, s + 4 + 4 * i);

    // B: all four requesting, 1 ms each, round-robin 0,1,2,3,0.
    rst = 1'b1;
    wait_neg(1);
    rst    = 1'b0;
    req    = 4'b1111;
    dur_ms = {4{16'd1}};
    s      = ecnt + 1;
    for (int k = 0; k < 5; k++) push(4'b0001 << (k % 4), s + 7 * k + 5);
    tick_q.delete();
    wait_neg(34);
    req = 4'b0000;
    wait_neg(2);
    check("B_tick_cnt", tick_q.size(), 5);
    check("B_busy_end", int'(busy), 0);

    // C: zero duration.
    req    = 4'b0010;
    dur_ms = 64'd0;
    s      = ecnt + 1;
    push(4'b0010, s + 1);
    tick_q.delete();
    wait_neg(1);
    check("C_gnt1", int'(gnt), 2);
    wait_neg(1);
    check("C_gnt2", int'(gnt), 2);
    req = 4'b0000;
    wait_neg(2);
    check("C_busy_end", int'(busy), 0);
    check("C_no_tick", tick_q.size(), 0);

    // D: reset mid-RUN, then requester 0 wins again.
    rst = 1'b1;
    wait_neg(1);
    rst    = 1'b0;
    req    = 4'b0001;
    dur_ms = 64'd5;
    wait_neg(8);
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    check("D_gnt0",  int'(gnt),  0);
    check("D_done0", int'(done), 0);
    check("D_busy0", int'(busy), 0);
    check("D_tick0", int'(tick), 0);
    req    = 4'b1001;
    dur_ms = 64'h0001_0000_0000_0001;
    s2     = ecnt + 1;
    push(4'b0001, s2 + 5);
    wait_neg(1);
    check("D_regrant", int'(gnt), 1);
    wait_neg(5);
    req = 4'b0000;
    wait_neg(2);

    // E: request dropped and duration changed after LOAD.
    req    = 4'b0100;
    dur_ms = 64'h0000_0002_0000_0000;
    s      = ecnt + 1;
    push(4'b0100, s + 9);
    wait_neg(2);
    req    = 4'b0000;
    dur_ms = 64'h0000_0009_0000_0000;
    wait_neg(8);
    wait_neg(1);
    check("E_busy_end", int'(busy), 0);

    // G: requester still asserting after done yields to another one.
    req    = 4'b0011;
    dur_ms = 64'd0;
    s      = ecnt + 1;
    push(4'b0001, s + 1);
    push(4'b0010, s + 4);
    push(4'b0001, s + 7);
    wait_neg(5);
    req = 4'b0001;
    wait_neg(3);
    req = 4'b0000;
    wait_neg(2);
    check("G_busy_end", int'(busy), 0);

`ifdef TRAIN_TIMER_ABORT_EN
    // F: abort during RUN, then requester 3 wins.
    req    = 4'b0001;
    dur_ms = 64'd10;
    wait_neg(6);
    abort = 1'b1;
    wait_neg(1);
    abort = 1'b0;
    check("F_gnt_abort",  int'(gnt),  0);
    check("F_busy_abort", int'(busy), 0);
    req    = 4'b1001;
    dur_ms = 64'h0001_0000_0000_0001;
    s2     = ecnt + 1;
    push(4'b1000, s2 + 5);
    wait_neg(1);
    check("F_gnt3", int'(gnt), 8);
    wait_neg(5);
    req = 4'b0000;
    wait_neg(2);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/train_timer_arbiter.md
TRAIN_TIMER_ARBITER -- requirements
Module: train_timer_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, prescaler cycles per 1 ms tick at 100 MHz (legal 2..2^17).
REQ-002 SHALL have port clk_100mhz  input  1  system clock; all logic on rising edge, single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester request, level, held until done.
REQ-005 SHALL have port dur_ms  input  64  four 16-bit durations in ms; requester i at bits [16i+15:16i].
REQ-006 SHALL have port gnt  output  4  one-hot owner of the shared timer; all zero when idle.
REQ-007 SHALL have port done  output  4  one-cycle completion pulse to the owning requester.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port tick  output  1  one-cycle 1 ms strobe while RUN.

Function
REQ-010 SHALL be an FSM with states IDLE, LOAD, RUN, DONE.
REQ-011 IDLE: if req != 0, SHALL select one requester round-robin, searching from (last_gnt+1) mod 4 upward, and go to LOAD; else stay.
REQ-012 LOAD: gnt SHALL be one-hot for the winner; SHALL latch its 16-bit dur_ms slice into remaining; SHALL update last_gnt; next state RUN if latched value != 0, else DONE.
REQ-013 Prescaler (17-bit) SHALL be 0 outside RUN, increment every RUN cycle, wrap to 0 at TICK_DIV-1 and assert tick in that same cycle.
REQ-014 RUN: on tick, remaining SHALL decrement by 1; on the tick where remaining == 1, next state SHALL be DONE.
REQ-015 DONE: done[winner] SHALL be 1 for exactly that cycle, gnt held; next state IDLE.
REQ-016 Latency: for dur = D > 0, done SHALL assert exactly D*TICK_DIV + 2 cycles after the IDLE cycle that sampled req; for D = 0, exactly 2 cycles.
REQ-017 gnt SHALL stay constant from LOAD through DONE; changes of req or dur_ms after LOAD SHALL be ignored.
REQ-018 Requester deasserting req mid-RUN SHALL NOT stop the timer; done still pulses.
REQ-019 A requester still asserting req in the IDLE cycle after its done SHALL be re-granted only if no other requester is asserting.
REQ-020 D = 65535 SHALL run to completion with no wrap-around of remaining.

Reset
REQ-021 rst high at any edge SHALL force state IDLE, gnt=0, done=0, busy=0, tick=0, prescaler=0, remaining=0, last_gnt=3 (so requester 0 has first priority).
REQ-022 rst mid-RUN SHALL abandon the request with no done pulse; rst has priority over every other input.

Configuration
REQ-023 Macro TRAIN_TIMER_ABORT_EN defined: port abort  input  1 SHALL exist; abort high in LOAD or RUN SHALL return the FSM to IDLE next cycle, clearing gnt, prescaler and remaining, with no done pulse; last_gnt keeps the aborted winner.
REQ-024 Macro not defined: no abort port; a granted request always completes through DONE.

Verification (TICK_DIV=4)
REQ-025 rst 1 cycle, then req=0001, dur0=3 -> gnt=0001 at cycle 1, tick at cycles 5,9,13, done[0] at cycle 14, busy low at 15.
REQ-026 req=1111, all dur=1 -> grant order 0,1,2,3,0; each done 6 cycles after its grant-sampling IDLE cycle.
REQ-027 req=0010, dur1=0 -> gnt=0010 for 2 cycles, done[1] 2 cycles after sampling, tick never asserts.
REQ-028 req=0001, dur0=5, rst pulsed at cycle 8 -> all outputs 0 at cycle 9, no done[0]; next grant goes to requester 0.
REQ-029 req=0100, dur2=2, req dropped at cycle 3 and dur2 changed to 9 -> done[2] still at cycle 10.
REQ-030 TRAIN_TIMER_ABORT_EN: req=0001, dur0=10, abort at cycle 6 -> IDLE at 7, gnt=0, no done; req=1001 then -> requester 3 granted.
